// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: machine word and the RAM handshake state.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/memory_types_pkg.sv
// Types and constants for the memory arbiter: FSM states, port owner
// encoding, error read-back word and starvation counter width.
package memory_types_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  localparam word_t       ERR_WORD_DEFAULT = 32'hBAD1BAD1;
  localparam int unsigned STARVE_W         = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants completed while an instruction fetch waits.
// Ports: clk/rst_n (async active-low), inc (count one), clr (return to 0,
// dominates inc), at_max (count has reached MAX).
module arb_starve_counter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == W'(MAX));

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates the single RAM port between instruction fetch (read-only) and
// the data path (load/store). Data has priority unless an instruction fetch
// has been starved for STARVE_MAX data grants.
// Ports: CLK, nRST (async active-low); iREN/iaddr -> iwait/iload;
// dREN/dWEN/daddr/dstore -> dwait/dload; merr error pulse;
// ramREN/ramWEN/ramaddr/ramstore -> RAM, ramload/ramstate <- RAM.
module memory_arbiter
  import cpu_types_pkg::*;
  import memory_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter word_t       ERR_WORD   = ERR_WORD_DEFAULT
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      merr,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  arb_state_t state_q, state_d;
  word_t      addr_q, addr_d;
  word_t      store_q, store_d;
  logic       wr_q, wr_d;

  arb_owner_t owner;
  logic       dreq, owner_req, ram_done, done;
  logic       starve_inc, starve_clr, starve_max;
  word_t      done_load;

  assign dreq      = dREN | dWEN;
  assign owner     = (state_q == DGRANT) ? OWN_D : OWN_I;
  assign owner_req = (owner == OWN_D) ? dreq : iREN;
  assign ram_done  = (ramstate == ACCESS) || (ramstate == ERROR);
  // A grant whose requester has withdrawn is an abort, never a completion.
  assign done      = (state_q != IDLE) && owner_req && ram_done;
  assign done_load = (ramstate == ERROR) ? ERR_WORD : ramload;

  arb_starve_counter #(
    .MAX (STARVE_MAX),
    .W   (STARVE_W)
  ) u_starve (
    .clk    (CLK),
    .rst_n  (nRST),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (starve_max)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (dreq && !(iREN && starve_max)) begin
          state_d = DGRANT;
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
        end else if (iREN) begin
          state_d = IGRANT;
          addr_d  = iaddr;
          store_d = '0;
          wr_d    = 1'b0;
        end
      end
      IGRANT, DGRANT: begin
        if (!owner_req || ram_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = iREN;
    dwait      = dreq;
    iload      = '0;
    dload      = '0;
    merr       = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        starve_clr = !iREN;
      end
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = addr_q;
        if (done) begin
          iwait      = 1'b0;
          iload      = done_load;
          merr       = (ramstate == ERROR);
          starve_clr = 1'b1;
        end
      end
      DGRANT: begin
        ramaddr  = addr_q;
        ramWEN   = wr_q;
        ramREN   = !wr_q;
        ramstore = store_q;
        if (done) begin
          dwait      = 1'b0;
          dload      = done_load;
          merr       = (ramstate == ERROR);
          starve_inc = iREN;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam word_t ERR_W = 32'hBAD1BAD1;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      iwait, dwait, merr, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  memory_arbiter #(.STARVE_MAX(4), .ERR_WORD(ERR_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .merr(merr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  // RAM model: ram_lat BUSY cycles, then ACCESS (or ERROR if ram_err).
  int    ram_lat = 0;
  bit    ram_err = 1'b0;
  word_t ram_data = 32'h8C220004 ^ 32'h40;
  int    bcnt = 0;

  always @(posedge CLK) begin
    if (ramREN || ramWEN) bcnt <= bcnt + 1;
    else bcnt <= 0;
  end

  always_comb begin
    ramstate = FREE;
    ramload  = '0;
    if (ramREN || ramWEN) begin
      ramload = ram_data ^ ramaddr;
      if (bcnt < ram_lat) ramstate = BUSY;
      else ramstate = ram_err ? ERROR : ACCESS;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit    is_d;
    word_t addr;
    bit    wr;
    word_t store;
    bit    err;
    word_t load;
    int    cyc;
  } exp_t;

  exp_t sb[$];
  int   done_cnt = 0;
  int   en_cyc = 0;

  task automatic push_exp(input bit is_d, input word_t addr, input bit wr, input word_t store);
    exp_t e;
    e.is_d  = is_d;
    e.addr  = addr;
    e.wr    = wr;
    e.store = store;
    e.err   = ram_err;
    e.load  = ram_err ? ERR_W : (ram_data ^ addr);
    e.cyc   = ram_lat + 1;
    sb.push_back(e);
  endtask

  // Completion monitor: pops the scoreboard whenever the RAM finishes a grant.
  always @(negedge CLK) begin
    exp_t e;
    if (nRST && (ramREN || ramWEN)) begin
      en_cyc++;
      if (ramstate == ACCESS || ramstate == ERROR) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("ramaddr", ramaddr, e.addr);
          check("ramWEN", ramWEN, e.is_d & e.wr);
          check("ramREN", ramREN, !(e.is_d & e.wr));
          check("grant_cycles", en_cyc, e.cyc);
          check("merr", merr, e.err);
          if (e.is_d) begin
            if (e.wr) check("ramstore", ramstore, e.store);
            check("dwait", dwait, 0);
            check("dload", dload, e.load);
            check("iwait_other", iwait, iREN);
            check("iload_other", iload, 0);
          end else begin
            check("iwait", iwait, 0);
            check("iload", iload, e.load);
            check("dwait_other", dwait, dREN | dWEN);
            check("dload_other", dload, 0);
          end
        end
        done_cnt++;
        en_cyc = 0;
      end
    end else begin
      en_cyc = 0;
    end
  end

  task automatic wait_done(input int target, input int budget, output int cyc);
    cyc = 0;
    while (done_cnt < target && cyc < budget) begin
      @(negedge CLK);
      #1;
      cyc++;
    end
    check("done_reached", (done_cnt >= target), 1);
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    int cyc;
    int base;
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b1;
    iaddr = 32'h44; daddr = 32'h48; dstore = 32'h1;
    #12;
    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    check("rst_merr", merr, 0);
    check("rst_iload", iload, 0);
    check("rst_dload", dload, 0);
    check("rst_iwait", iwait, 1);
    check("rst_dwait", dwait, 1);
    iREN = 1'b0; dWEN = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    step();
    check("idle_ramREN", ramREN, 0);

    // Lone fetch, single-cycle RAM.
    base = done_cnt;
    iREN = 1'b1; iaddr = 32'h40;
    push_exp(1'b0, 32'h40, 1'b0, '0);
    wait_done(base + 1, 10, cyc);
    check("fetch_latency", cyc, 1);
    iREN = 1'b0;
    step();
    check("fetch_idle_ramREN", ramREN, 0);

    // Simultaneous request: data write first (2 BUSY cycles), then fetch.
    ram_lat = 2;
    base = done_cnt;
    iREN = 1'b1; iaddr = 32'h80;
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD;
    push_exp(1'b1, 32'h100, 1'b1, 32'hDEAD);
    push_exp(1'b0, 32'h80, 1'b0, '0);
    wait_done(base + 1, 20, cyc);
    dWEN = 1'b0;
    wait_done(base + 2, 20, cyc);
    iREN = 1'b0;
    step();

    // Starvation: four data grants, then the fetch, then data again.
    ram_lat = 0;
    base = done_cnt;
    iREN = 1'b1; iaddr = 32'h200;
    dREN = 1'b1; daddr = 32'h300;
    for (int k = 0; k < 4; k++) push_exp(1'b1, 32'h300 + 32'(4 * k), 1'b0, '0);
    push_exp(1'b0, 32'h200, 1'b0, '0);
    push_exp(1'b1, 32'h310, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      wait_done(base + k + 1, 10, cyc);
      daddr = 32'h300 + 32'(4 * (k + 1));
    end
    wait_done(base + 5, 10, cyc);
    iREN = 1'b0;
    wait_done(base + 6, 10, cyc);
    dREN = 1'b0;
    step();

    // After the fetch the counter restarted: data wins again with iREN held.
    base = done_cnt;
    iREN = 1'b1; iaddr = 32'h204;
    dREN = 1'b1; daddr = 32'h320;
    push_exp(1'b1, 32'h320, 1'b0, '0);
    push_exp(1'b0, 32'h204, 1'b0, '0);
    wait_done(base + 1, 10, cyc);
    dREN = 1'b0;
    wait_done(base + 2, 10, cyc);
    iREN = 1'b0;
    step();

    // RAM error on a data read.
    ram_err = 1'b1;
    base = done_cnt;
    dREN = 1'b1; daddr = 32'h44;
    push_exp(1'b1, 32'h44, 1'b0, '0);
    wait_done(base + 1, 10, cyc);
    dREN = 1'b0;
    ram_err = 1'b0;
    step();
    check("err_merr_pulse", merr, 0);
    check("err_idle_ramREN", ramREN, 0);

    // Abort: withdraw a data read while the RAM is busy.
    ram_lat = 5;
    base = done_cnt;
    dREN = 1'b1; daddr = 32'h60;
    step();
    check("abort_ramREN_on", ramREN, 1);
    check("abort_ramaddr", ramaddr, 32'h60);
    dREN = 1'b0;
    step();
    check("abort_ramREN_off", ramREN, 0);
    check("abort_no_done", done_cnt, base);

    // Asynchronous reset in the middle of an instruction grant.
    iREN = 1'b1; iaddr = 32'h70;
    step();
    check("rstmid_ramREN_on", ramREN, 1);
    nRST = 1'b0;
    #1;
    check("rstmid_ramREN", ramREN, 0);
    check("rstmid_ramaddr", ramaddr, 0);
    check("rstmid_iwait", iwait, 1);
    iREN = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    step();

    // Read/write tie resolves to a write.
    ram_lat = 0;
    base = done_cnt;
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h88; dstore = 32'h1234;
    push_exp(1'b1, 32'h88, 1'b1, 32'h1234);
    wait_done(base + 1, 10, cyc);
    dREN = 1'b0; dWEN = 1'b0;
    step();

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
